// File: rtl/hist2d_core.sv
// hist2d_core: streaming 2D I/Q histogrammer with RAM-backed bin counters.
// Stream mode reports each updated bin; batch mode dumps and clears the grid after num_data_pts samples.
module hist2d_core #(
  parameter int MAX_I_BINS = 16,
  parameter int MAX_Q_BINS = 16
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic        data_in,
  input  logic [31:0] i_val,
  input  logic [31:0] q_val,
  input  logic [7:0]  i_bin_num,
  input  logic [7:0]  q_bin_num,
  input  logic [15:0] i_bin_width,
  input  logic [15:0] q_bin_width,
  input  logic [15:0] i_min,
  input  logic [15:0] q_min,
  input  logic [15:0] num_data_pts,
  input  logic        stream_mode,
  output logic        i_q_found,
  output logic        bin_found,
  output logic [7:0]  i_bin_coord,
  output logic [7:0]  q_bin_coord,
  output logic [15:0] bin_val
);
  localparam int DEPTH = MAX_I_BINS * MAX_Q_BINS;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {CLEAR, IDLE, SEARCH, UPD_RD, UPD_WR, FIN, DUMP} state_t;
  state_t state;
  logic data_prev, mode, dend, p_v, q_end, i_end, we;
  logic [15:0] npts, cnt, rd_q, inc;
  logic [15:0] mem [DEPTH];
  logic [1:0][31:0] val;
  logic [1:0][15:0] w, mn;
  logic [1:0][7:0] bn, idx;
  logic [1:0][32:0] acc, off;
  logic [1:0] done, oor, miss, hit;
  logic [7:0] d_i, d_q, p_i, p_q, lim_i, lim_q;
  logic [AW-1:0] addr;
  // index 0 is the I axis, index 1 the Q axis
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      off[a] = {val[a][31], val[a]} - {{17{mn[a][15]}}, mn[a]};
      miss[a] = off[a][32] || idx[a] == bn[a];
      hit[a] = !miss[a] && off[a] < acc[a] + {17'd0, w[a]};
    end
  end
  assign lim_i = state == CLEAR ? 8'(MAX_I_BINS) : bn[0];
  assign lim_q = state == CLEAR ? 8'(MAX_Q_BINS) : bn[1];
  assign q_end = d_q == lim_q - 8'd1;
  assign i_end = d_i == lim_i - 8'd1;
  assign inc = rd_q == 16'hFFFF ? rd_q : rd_q + 16'd1;
  assign we = rst_n && (state == CLEAR || state == UPD_WR || (state == DUMP && !dend));
  assign addr = (state == UPD_RD || state == UPD_WR) ? AW'(32'(idx[0]) * MAX_Q_BINS + 32'(idx[1]))
                                                     : AW'(32'(d_i) * MAX_Q_BINS + 32'(d_q));
  // read-before-write: a dump reads the old count while clearing the same word
  always_ff @(posedge clk100) begin
    if (we) mem[addr] <= state == UPD_WR ? inc : 16'd0;
    rd_q <= mem[addr];
  end
  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt <= 16'd0;
      d_i <= 8'd0;
      d_q <= 8'd0;
      data_prev <= 1'b0;
      i_q_found <= 1'b0;
      bin_found <= 1'b0;
      i_bin_coord <= 8'd0;
      q_bin_coord <= 8'd0;
      bin_val <= 16'd0;
    end else begin
      data_prev <= data_in;
      i_q_found <= 1'b0;
      bin_found <= 1'b0;
      case (state)
        CLEAR: begin
          d_q <= q_end ? 8'd0 : d_q + 8'd1;
          d_i <= q_end ? d_i + 8'd1 : d_i;
          if (q_end && i_end) state <= IDLE;
        end
        IDLE: if (data_in && !data_prev) begin
          val <= {q_val, i_val};
          w <= {q_bin_width == 16'd0 ? 16'd1 : q_bin_width, i_bin_width == 16'd0 ? 16'd1 : i_bin_width};
          mn <= {q_min, i_min};
          bn <= {q_bin_num > 8'(MAX_Q_BINS) ? 8'(MAX_Q_BINS) : q_bin_num,
                 i_bin_num > 8'(MAX_I_BINS) ? 8'(MAX_I_BINS) : i_bin_num};
          acc <= '0;
          idx <= '0;
          done <= '0;
          oor <= '0;
          if (cnt == 16'd0) begin
            mode <= stream_mode;
            npts <= num_data_pts == 16'd0 ? 16'd1 : num_data_pts;
          end
          state <= SEARCH;
        end
        SEARCH: begin
          for (int a = 0; a < 2; a++) begin
            if (!done[a]) begin
              done[a] <= miss[a] || hit[a];
              oor[a] <= miss[a];
              if (!miss[a] && !hit[a]) begin
                acc[a] <= acc[a] + {17'd0, w[a]};
                idx[a] <= idx[a] + 8'd1;
              end
            end
          end
          if (&done && |oor) state <= FIN;
          else if (&done) begin
            i_q_found <= 1'b1;
            i_bin_coord <= idx[0];
            q_bin_coord <= idx[1];
            state <= UPD_RD;
          end
        end
        UPD_RD: state <= UPD_WR;
        UPD_WR: begin
          bin_found <= mode;
          bin_val <= mode ? inc : bin_val;
          state <= FIN;
        end
        FIN: begin
          cnt <= mode ? 16'd0 : cnt + 16'd1;
          d_i <= 8'd0;
          d_q <= 8'd0;
          p_v <= 1'b0;
          dend <= bn[0] == 8'd0 || bn[1] == 8'd0;
          state <= !mode && cnt + 16'd1 == npts ? DUMP : IDLE;
        end
        DUMP: begin
          bin_found <= p_v;
          if (p_v) begin
            i_bin_coord <= p_i;
            q_bin_coord <= p_q;
            bin_val <= rd_q;
          end
          p_v <= !dend;
          if (!dend) begin
            p_i <= d_i;
            p_q <= d_q;
            d_q <= q_end ? 8'd0 : d_q + 8'd1;
            d_i <= q_end ? d_i + 8'd1 : d_i;
            dend <= q_end && i_end;
          end else if (!p_v) begin
            cnt <= 16'd0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hist2d_core.sv
// tb_hist2d_core: directed checks of hist2d_core binning, stream updates, batch dumps and reset.
module tb_hist2d_core;
  logic clk100 = 1'b0, rst_n = 1'b0, data_in = 1'b0, stream_mode = 1'b0;
  logic [31:0] i_val = '0, q_val = '0;
  logic [7:0] i_bin_num = '0, q_bin_num = '0;
  logic [15:0] i_bin_width = '0, q_bin_width = '0, i_min = '0, q_min = '0, num_data_pts = '0;
  logic i_q_found, bin_found;
  logic [7:0] i_bin_coord, q_bin_coord;
  logic [15:0] bin_val;
  int total = 0, bad = 0, cyc = 0;
  int model[16][16];
  int st_t[$], iq_i[$], iq_q[$], iq_t[$], bf_i[$], bf_q[$], bf_v[$], bf_t[$];

  hist2d_core dut (
    .clk100(clk100), .rst_n(rst_n), .data_in(data_in), .i_val(i_val), .q_val(q_val),
    .i_bin_num(i_bin_num), .q_bin_num(q_bin_num), .i_bin_width(i_bin_width),
    .q_bin_width(q_bin_width), .i_min(i_min), .q_min(q_min), .num_data_pts(num_data_pts),
    .stream_mode(stream_mode), .i_q_found(i_q_found), .bin_found(bin_found),
    .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord), .bin_val(bin_val)
  );

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;
  always @(negedge clk100) begin
    if (i_q_found) begin
      iq_i.push_back(int'(i_bin_coord));
      iq_q.push_back(int'(q_bin_coord));
      iq_t.push_back(cyc);
    end
    if (bin_found) begin
      bf_i.push_back(int'(i_bin_coord));
      bf_q.push_back(int'(q_bin_coord));
      bf_v.push_back(int'(bin_val));
      bf_t.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int at(input int q[$], input int k);
    return k < q.size() ? q[k] : -1;
  endfunction

  task automatic flush;
    st_t.delete(); iq_i.delete(); iq_q.delete(); iq_t.delete();
    bf_i.delete(); bf_q.delete(); bf_v.delete(); bf_t.delete();
  endtask

  task automatic cfg(input int ni, input int nq, input int wi, input int wq,
                     input int mi, input int mq, input int np, input logic sm);
    i_bin_num = 8'(ni); q_bin_num = 8'(nq);
    i_bin_width = 16'(wi); q_bin_width = 16'(wq);
    i_min = 16'(mi); q_min = 16'(mq);
    num_data_pts = 16'(np); stream_mode = sm;
  endtask

  task automatic strobe(input int iv, input int qv, input int hold, input int gap);
    @(negedge clk100);
    i_val = 32'(iv); q_val = 32'(qv); data_in = 1'b1;
    st_t.push_back(cyc + 1);
    repeat (hold) @(negedge clk100);
    data_in = 1'b0;
    repeat (gap) @(negedge clk100);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_iqf"}, int'(i_q_found), 0);
    chk({tag, "_bf"}, int'(bin_found), 0);
    chk({tag, "_ic"}, int'(i_bin_coord), 0);
    chk({tag, "_qc"}, int'(q_bin_coord), 0);
    chk({tag, "_val"}, int'(bin_val), 0);
  endtask

  task automatic check_dump(input int ni, input int nq, input string tag);
    int n;
    n = ni * nq;
    for (int k = 0; k < 2000 && bf_i.size() < n; k++) @(negedge clk100);
    repeat (4) @(negedge clk100);
    chk({tag, "_count"}, bf_i.size(), n);
    for (int k = 0; k < n && k < bf_i.size(); k++) begin
      chk($sformatf("%s_i%0d", tag, k), bf_i[k], k / nq);
      chk($sformatf("%s_q%0d", tag, k), bf_q[k], k % nq);
      chk($sformatf("%s_v%0d", tag, k), bf_v[k], model[k / nq][k % nq]);
      chk($sformatf("%s_t%0d", tag, k), bf_t[k] - bf_t[0], k);
    end
    for (int i = 0; i < ni; i++)
      for (int q = 0; q < nq; q++) model[i][q] = 0;
    flush();
  endtask

  initial begin
    int ei[3], eq[3], el[3], ev[3];
    foreach (model[i, q]) model[i][q] = 0;
    repeat (3) @(negedge clk100);
    chk_idle_outputs("rst");
    rst_n = 1'b1;
    repeat (270) @(negedge clk100);
    // two identical batches; the second proves the first dump cleared the grid
    for (int r = 0; r < 2; r++) begin
      flush();
      cfg(10, 10, 1, 1, 0, 0, 5, 1'b0);
      strobe(-3, -3, 1, 16);
      strobe(-2, -2, 1, 16);
      strobe(-1, -1, 1, 16);
      strobe(0, 0, 1, 16);
      strobe(1, 1, 1, 16);
      chk($sformatf("b%0d_iq_n", r), iq_i.size(), 2);
      chk($sformatf("b%0d_iq0_c", r), at(iq_i, 0) * 16 + at(iq_q, 0), 0);
      chk($sformatf("b%0d_iq1_c", r), at(iq_i, 1) * 16 + at(iq_q, 1), 17);
      chk($sformatf("b%0d_iq0_lat", r), at(iq_t, 0) - st_t[3], 2);
      chk($sformatf("b%0d_iq1_lat", r), at(iq_t, 1) - st_t[4], 3);
      model[0][0] = 1;
      model[1][1] = 1;
      check_dump(10, 10, $sformatf("b%0d", r));
    end
    // stream mode, third strobe held high to count once
    flush();
    cfg(10, 10, 1, 1, 0, 0, 1, 1'b1);
    strobe(4, 7, 1, 20);
    strobe(4, 7, 1, 20);
    strobe(4, 7, 30, 20);
    chk("s_iq_n", iq_i.size(), 3);
    chk("s_bf_n", bf_i.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("s_iq%0d_c", k), at(iq_i, k) * 16 + at(iq_q, k), 4 * 16 + 7);
      chk($sformatf("s_iq%0d_lat", k), at(iq_t, k) - st_t[k], 9);
      chk($sformatf("s_bf%0d_c", k), at(bf_i, k) * 16 + at(bf_q, k), 4 * 16 + 7);
      chk($sformatf("s_bf%0d_v", k), at(bf_v, k), k + 1);
      chk($sformatf("s_bf%0d_lat", k), at(bf_t, k) - at(iq_t, k), 2);
    end
    model[4][7] = 3;
    // width 3, min -6, 5x5: I -6,-4,8 -> bins 0,0,4; I 9 out of range; Q 0 -> bin 2
    flush();
    cfg(5, 5, 3, 3, -6, -6, 1, 1'b1);
    strobe(-6, 0, 1, 20);
    strobe(-4, 0, 1, 20);
    strobe(8, 0, 1, 20);
    strobe(9, 0, 1, 20);
    ei = '{0, 0, 4}; eq = '{2, 2, 2}; el = '{4, 4, 6}; ev = '{1, 2, 1};
    chk("g_iq_n", iq_i.size(), 3);
    chk("g_bf_n", bf_i.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("g_iq%0d_i", k), at(iq_i, k), ei[k]);
      chk($sformatf("g_iq%0d_q", k), at(iq_q, k), eq[k]);
      chk($sformatf("g_iq%0d_lat", k), at(iq_t, k) - st_t[k], el[k]);
      chk($sformatf("g_bf%0d_v", k), at(bf_v, k), ev[k]);
    end
    model[0][2] = 2;
    model[4][2] = 1;
    // width 0 acts as 1, num_data_pts 0 acts as 1: every sample dumps
    flush();
    cfg(4, 4, 0, 0, 0, 0, 0, 1'b0);
    strobe(2, 3, 1, 4);
    model[2][3] = 1;
    check_dump(4, 4, "w0a");
    strobe(1, 1, 1, 4);
    model[1][1] = 1;
    check_dump(4, 4, "w0b");
    strobe(9, 0, 1, 10);
    chk("w0c_iq_n", iq_i.size(), 0);
    check_dump(4, 4, "w0c");
    // reset in the middle of a dump, then a fresh batch
    flush();
    cfg(10, 10, 1, 1, 0, 0, 1, 1'b0);
    strobe(5, 5, 1, 30);
    chk("pre_rst_bf", int'(bin_found), 1);
    rst_n = 1'b0;
    @(negedge clk100);
    chk_idle_outputs("mid_rst");
    repeat (2) @(negedge clk100);
    rst_n = 1'b1;
    repeat (270) @(negedge clk100);
    foreach (model[i, q]) model[i][q] = 0;
    flush();
    cfg(10, 10, 1, 1, 0, 0, 2, 1'b0);
    strobe(3, 4, 1, 16);
    strobe(9, 9, 1, 16);
    model[3][4] = 1;
    model[9][9] = 1;
    check_dump(10, 10, "rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hist2d_core.md
Name: hist2d_core

Overview:
- Streaming 2D histogrammer for I/Q readout samples.
- Each strobed (i_val, q_val) pair is binned against a runtime-programmable grid, and the matching bin counter is incremented in on-chip RAM.
- Stream mode reports each updated bin immediately; batch mode collects num_data_pts samples, then dumps and clears the whole grid.
- Sits after the I/Q demodulator, feeding the host readout path.

Parameters:
- MAX_I_BINS, 16, RAM depth along I (index width 8).
- MAX_Q_BINS, 16, RAM depth along Q.

Ports:
- clk100  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- data_in  in  1  sample strobe; rising edge accepts a sample.
- i_val  in  32  signed I sample.
- q_val  in  32  signed Q sample.
- i_bin_num  in  8  number of I bins used, clamped to MAX_I_BINS.
- q_bin_num  in  8  number of Q bins used, clamped to MAX_Q_BINS.
- i_bin_width  in  16  I bin width, unsigned; 0 is treated as 1.
- q_bin_width  in  16  Q bin width, unsigned; 0 is treated as 1.
- i_min  in  16  signed lower edge of I bin 0.
- q_min  in  16  signed lower edge of Q bin 0.
- num_data_pts  in  16  samples per batch; 0 is treated as 1.
- stream_mode  in  1  1 = per-sample report, 0 = batch dump.
- i_q_found  out  1  one-cycle pulse: sample landed in range; coords valid.
- bin_found  out  1  one-cycle pulse: i_bin_coord, q_bin_coord, bin_val valid.
- i_bin_coord  out  8  I bin index.
- q_bin_coord  out  8  Q bin index.
- bin_val  out  16  bin count.

Behaviour:
- Reset (rst_n low at an edge):
  - All outputs go to 0, the sample counter goes to 0, and the FSM enters CLEAR.
  - CLEAR writes 0 to all MAX_I_BINS*MAX_Q_BINS RAM words, one per cycle, then goes to IDLE.
  - data_in is ignored outside IDLE.
  - Reset mid-operation aborts any search, update or dump, with the same result.
- RAM: address = i_idx*MAX_Q_BINS + q_idx, 16-bit words, 1-cycle read latency. Counts saturate at 0xFFFF.
- IDLE:
  - A rising edge of data_in (registered previous value) latches i_val, q_val and all configuration inputs.
  - On the first sample of a batch it also latches stream_mode and num_data_pts.
  - Goes to SEARCH.
- SEARCH:
  - off = val − sign_extend(min), computed at 33 bits. If off < 0 the axis is out of range.
  - Otherwise each cycle tests off < acc + width, starting from acc = 0 and idx = 0.
    - Test true: the axis is done at idx.
    - Test false: acc += width and idx++.
    - idx reaching bin_num before the test is true: the axis is out of range.
  - The I and Q axes search in parallel; SEARCH ends when both are resolved.
- SEARCH outcome:
  - Both axes in range: i_q_found pulses for one cycle, coords are updated (and held until the next update), then UPDATE.
  - Either axis out of range: the sample is discarded, with no i_q_found and no RAM change. It still counts toward num_data_pts.
- UPDATE:
  - Read the RAM word, then write word+1 on the next cycle.
  - In stream mode: bin_found pulses on the write cycle with bin_val = new count.
  - Then the sample counter increments.
- Mode handling after a sample:
  - Stream mode: return to IDLE; the counter is unused.
  - Batch mode: if the counter equals num_data_pts, go to DUMP; otherwise go to IDLE.
- DUMP:
  - Bins are scanned with i outer and q inner: (0,0), (0,1) … (i_bin_num−1, q_bin_num−1).
  - Each bin produces one bin_found pulse with its coords and value, on consecutive cycles (pipelined read).
  - Each word is written to 0 after it is read.
  - Then the counter is cleared and the FSM returns to IDLE.
- Latency: for a strobe sampled at cycle N, i_q_found asserts at N+2+max(i_idx, q_idx). bin_found (stream) asserts 2 cycles later.
- Edge cases:
  - data_in held high counts as one sample.
  - A strobe arriving while busy is dropped.
  - Configuration changes take effect only at acceptance.

Test Plan:
- Reset, bins 10×10, width 1, min 0, batch of 5. Samples (−3,−3), (−2,−2), (−1,−1), (0,0), (1,1), one strobe every 16 cycles -> i_q_found only for (0,0) and (1,1). Then 100 consecutive bin_found pulses: (0,0)=1, (1,1)=1, all others 0, in i-major order.
- Repeat the same batch immediately after -> identical dump, proving the clear-on-dump.
- Stream mode: sample (4,7) three times, width 1, min 0 -> bin_found at (4,7) with bin_val 1, 2, 3; i_q_found latency 9 cycles.
- Width 3, min −6, 5×5 bins: I = −6, −4, 8, 9, Q = 0 -> I bins 0, 0, 4, out of range; Q bin 2.
- Width 0 is treated as 1; num_data_pts = 0 is treated as 1 -> each in-range sample triggers a full dump.
- Assert rst_n low during DUMP -> outputs 0. After the CLEAR sweep completes, a fresh batch dumps all zeros except the newly written bins.
